// File: rtl/inst_fetch.sv
// inst_fetch -- instruction fetch sequencer for the 4-bit core.
//
// This block fetches an opcode nibble from program memory over a REQ/ACK
// handshake. It presents the opcode to the decoder on D and pulses LATCH.
// It then reads back the decoder's JMP/LDD flags and, when either is set,
// fetches the operand nibbles. For a jump, the AW/4 operand nibbles are
// assembled MS nibble first into a new PC. For a load-immediate, the single
// operand nibble is presented on IMM together with a one-cycle IMM_VLD pulse.
//
// Ports
//   CLK       in   clock; all state changes on the rising edge
//   RST       in   synchronous reset, active low
//   HOLD      in   core stall; only looked at while idle
//   MEM_ACK   in   memory acknowledge; MEM_DATA is valid in the same cycle
//   MEM_DATA  in   program nibble from memory
//   JMP, LDD  in   decoder outputs for the currently latched opcode
//   ADDR      out  program memory address (always the PC)
//   MEM_REQ   out  memory request; held until MEM_ACK
//   D         out  opcode nibble to the decoder; holds between fetches
//   LATCH     out  one-cycle strobe; decoder captures D at the end of it
//   IMM       out  load-immediate nibble
//   IMM_VLD   out  one-cycle pulse when IMM is updated
//   PC        out  program counter
module inst_fetch #(
  parameter int            AW       = 12,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          HOLD,
  input  logic          MEM_ACK,
  input  logic [3:0]    MEM_DATA,
  input  logic          JMP,
  input  logic          LDD,
  output logic [AW-1:0] ADDR,
  output logic          MEM_REQ,
  output logic [3:0]    D,
  output logic          LATCH,
  output logic [3:0]    IMM,
  output logic          IMM_VLD,
  output logic [AW-1:0] PC
);

  localparam int CW = $clog2(AW/4 + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_ARG   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] target_q, target_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_jmp_q, is_jmp_d;
  logic          req_q, req_d;
  logic [3:0]    d_q, d_d;
  logic          latch_q, latch_d;
  logic [3:0]    imm_q, imm_d;
  logic          imm_vld_q, imm_vld_d;

  // Target with the incoming nibble shifted in at the bottom; the top nibble
  // falls off, so after AW/4 nibbles the first one received is the MS nibble.
  logic [AW+3:0] tgt_wide;
  logic [AW-1:0] tgt_next;
  logic          ack;

  assign tgt_wide = {target_q, MEM_DATA};
  assign tgt_next = tgt_wide[AW-1:0];
  // An acknowledge only counts while a request is outstanding.
  assign ack      = MEM_ACK && req_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    is_jmp_d  = is_jmp_q;
    req_d     = req_q;
    d_d       = d_q;
    imm_d     = imm_q;
    latch_d   = 1'b0;
    imm_vld_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!HOLD) begin
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (ack) begin
          d_d     = MEM_DATA;
          pc_d    = pc_q + AW'(1);
          req_d   = 1'b0;
          latch_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CHECK;
      S_CHECK: begin
        // JMP wins when the decoder flags both.
        if (JMP) begin
          is_jmp_d = 1'b1;
          cnt_d    = CW'(AW/4);
          target_d = '0;
          req_d    = 1'b1;
          state_d  = S_ARG;
        end else if (LDD) begin
          is_jmp_d = 1'b0;
          cnt_d    = CW'(1);
          req_d    = 1'b1;
          state_d  = S_ARG;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ARG: begin
        if (ack) begin
          cnt_d = cnt_q - CW'(1);
          pc_d  = pc_q + AW'(1);
          if (is_jmp_q) target_d = tgt_next;
          if (cnt_q == CW'(1)) begin
            req_d   = 1'b0;
            state_d = S_IDLE;
            if (is_jmp_q) begin
              pc_d = tgt_next;
            end else begin
              imm_d     = MEM_DATA;
              imm_vld_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      target_q  <= '0;
      cnt_q     <= '0;
      is_jmp_q  <= 1'b0;
      req_q     <= 1'b0;
      d_q       <= 4'h0;
      latch_q   <= 1'b0;
      imm_q     <= 4'h0;
      imm_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      is_jmp_q  <= is_jmp_d;
      req_q     <= req_d;
      d_q       <= d_d;
      latch_q   <= latch_d;
      imm_q     <= imm_d;
      imm_vld_q <= imm_vld_d;
    end
  end

  assign ADDR    = pc_q;
  assign PC      = pc_q;
  assign MEM_REQ = req_q;
  assign D       = d_q;
  assign LATCH   = latch_q;
  assign IMM     = imm_q;
  assign IMM_VLD = imm_vld_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch (AW=12, RESET_PC=0). Program memory, the
// REQ/ACK responder and a tiny decoder (opcode 1 = jump, 2 = load-immediate,
// F = both, anything else plain) live here. All stimulus and sampling happen
// just after the falling edge.
module tb_inst_fetch;
  localparam int AW = 12;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          HOLD = 1'b1;
  logic          MEM_ACK = 1'b0;
  logic [3:0]    MEM_DATA = 4'h0;
  logic          JMP, LDD;
  logic [AW-1:0] ADDR, PC;
  logic          MEM_REQ, LATCH, IMM_VLD;
  logic [3:0]    D, IMM;

  inst_fetch #(.AW(AW), .RESET_PC(12'h000)) dut (
    .CLK(CLK), .RST(RST), .HOLD(HOLD), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
    .JMP(JMP), .LDD(LDD), .ADDR(ADDR), .MEM_REQ(MEM_REQ), .D(D),
    .LATCH(LATCH), .IMM(IMM), .IMM_VLD(IMM_VLD), .PC(PC)
  );

  always #5 CLK = ~CLK;

  // decoder model
  logic [3:0] dec_op = 4'h0;
  always @(posedge CLK) begin
    if (!RST) dec_op <= 4'h0;
    else if (LATCH) dec_op <= D;
  end
  assign JMP = (dec_op == 4'h1) || (dec_op == 4'hF);
  assign LDD = (dec_op == 4'h2) || (dec_op == 4'hF);

  // memory responder: acks after wait_n wait cycles; slow_addr never acks
  logic [3:0]    mem [4096];
  int            wait_n = 0;
  logic          slow_en = 1'b0;
  logic [AW-1:0] slow_addr = 12'hFFF;
  int            wcnt = 0;
  int            lim;
  always @(negedge CLK) begin
    MEM_ACK = 1'b0;
    lim = (slow_en && ADDR == slow_addr) ? 1000000 : wait_n;
    if (MEM_REQ) begin
      if (wcnt >= lim) begin
        MEM_ACK = 1'b1;
        MEM_DATA = mem[ADDR];
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
  end

  // monitor: counters only ever grow; tests take a baseline snapshot
  int            cyc = 0;
  always @(posedge CLK) cyc++;
  int            nreq = 0, latch_cnt = 0, imm_cnt = 0, both_cnt = 0;
  logic          prev_req = 1'b0;
  logic [AW-1:0] req_a [256];
  int            req_t [256];
  logic [3:0]    latch_dv = 4'h0;
  always @(negedge CLK) begin
    if (MEM_REQ && !prev_req && nreq < 256) begin
      req_a[nreq] = ADDR;
      req_t[nreq] = cyc;
      nreq++;
    end
    prev_req = MEM_REQ;
    if (LATCH) begin latch_cnt++; latch_dv = D; end
    if (IMM_VLD) imm_cnt++;
    if (LATCH && IMM_VLD) both_cnt++;
  end

  int tests = 0, fails = 0;
  int b_req, b_lat, b_imm;

  task automatic tick();
    @(negedge CLK); #1;
  endtask

  task automatic snap();
    b_req = nreq; b_lat = latch_cnt; b_imm = imm_cnt;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 4'h3;
  endtask

  task automatic do_reset();
    HOLD = 1'b1; RST = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic wait_reqs(input int n);
    for (int i = 0; i < 200 && (nreq - b_req) < n; i++) tick();
  endtask

  task automatic test_reset();
    clear_mem(); wait_n = 0; slow_en = 1'b0;
    HOLD = 1'b0; RST = 1'b0;
    repeat (3) tick();
    tests++; if (PC !== 12'h000) begin fails++; $display("FAIL reset_pc: got %h want 000", PC); end
    tests++; if (MEM_REQ !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", MEM_REQ); end
    tests++; if (LATCH !== 1'b0 || IMM_VLD !== 1'b0) begin fails++; $display("FAIL reset_strobes: latch %b imm_vld %b want 0 0", LATCH, IMM_VLD); end
    tests++; if (D !== 4'h0 || IMM !== 4'h0) begin fails++; $display("FAIL reset_d_imm: d %h imm %h want 0 0", D, IMM); end
    RST = 1'b1;
    tick();
    tests++; if (MEM_REQ !== 1'b1 || ADDR !== 12'h000) begin fails++; $display("FAIL reset_first_req: req %b addr %h want 1 000", MEM_REQ, ADDR); end
  endtask

  task automatic test_plain();
    clear_mem(); wait_n = 0;
    do_reset(); snap();
    HOLD = 1'b0;
    wait_reqs(2);
    tests++; if (nreq - b_req < 2) begin fails++; $display("FAIL plain_timeout: reqs %0d want 2", nreq - b_req); end
    tests++; if (req_a[b_req] !== 12'h000 || req_a[b_req+1] !== 12'h001) begin fails++; $display("FAIL plain_addrs: %h %h want 000 001", req_a[b_req], req_a[b_req+1]); end
    tests++; if (req_t[b_req+1] - req_t[b_req] != 4) begin fails++; $display("FAIL plain_period: %0d want 4", req_t[b_req+1] - req_t[b_req]); end
    tests++; if (latch_cnt - b_lat != 1 || latch_dv !== 4'h3) begin fails++; $display("FAIL plain_latch: cycles %0d d %h want 1 3", latch_cnt - b_lat, latch_dv); end
    tests++; if (PC !== 12'h001 || D !== 4'h3) begin fails++; $display("FAIL plain_pc_d: pc %h d %h want 001 3", PC, D); end
  endtask

  task automatic test_jump();
    clear_mem(); wait_n = 2;
    mem[0] = 4'h1; mem[1] = 4'hA; mem[2] = 4'hB; mem[3] = 4'hC;
    do_reset(); snap();
    HOLD = 1'b0;
    wait_reqs(3);
    tests++; if (nreq - b_req < 3) begin fails++; $display("FAIL jump_timeout: reqs %0d want 3", nreq - b_req); end
    tests++; if (req_a[b_req+1] !== 12'h001 || req_a[b_req+2] !== 12'hABC) begin fails++; $display("FAIL jump_addrs: %h %h want 001 abc", req_a[b_req+1], req_a[b_req+2]); end
    tests++; if (req_t[b_req+1] - req_t[b_req] != 5 || req_t[b_req+2] - req_t[b_req+1] != 10) begin fails++; $display("FAIL jump_timing: %0d %0d want 5 10", req_t[b_req+1] - req_t[b_req], req_t[b_req+2] - req_t[b_req+1]); end
    tests++; if (PC !== 12'hABC || imm_cnt != b_imm || D !== 4'h1) begin fails++; $display("FAIL jump_state: pc %h imm_pulses %0d d %h want abc 0 1", PC, imm_cnt - b_imm, D); end
  endtask

  task automatic test_ldd();
    clear_mem(); wait_n = 0;
    mem[0] = 4'h2; mem[1] = 4'h9;
    do_reset(); snap();
    HOLD = 1'b0;
    wait_reqs(3);
    tests++; if (IMM !== 4'h9 || imm_cnt - b_imm != 1) begin fails++; $display("FAIL ldd_imm: imm %h pulse_cycles %0d want 9 1", IMM, imm_cnt - b_imm); end
    tests++; if (PC !== 12'h002 || req_a[b_req+1] !== 12'h001 || req_a[b_req+2] !== 12'h002) begin fails++; $display("FAIL ldd_pc: pc %h arg %h next %h want 002 001 002", PC, req_a[b_req+1], req_a[b_req+2]); end
  endtask

  task automatic test_priority();
    clear_mem(); wait_n = 0;
    mem[0] = 4'hF; mem[1] = 4'h1; mem[2] = 4'h2; mem[3] = 4'h3;
    do_reset(); snap();
    HOLD = 1'b0;
    wait_reqs(3);
    tests++; if (req_a[b_req+2] !== 12'h123 || imm_cnt != b_imm) begin fails++; $display("FAIL prio_jump: next %h imm_pulses %0d want 123 0", req_a[b_req+2], imm_cnt - b_imm); end
  endtask

  task automatic test_hold();
    clear_mem(); wait_n = 2;
    mem[0] = 4'h2; mem[1] = 4'h5;
    do_reset(); snap();
    repeat (5) tick();
    tests++; if (nreq != b_req || MEM_REQ !== 1'b0) begin fails++; $display("FAIL hold_idle: reqs %0d req %b want 0 0", nreq - b_req, MEM_REQ); end
    HOLD = 1'b0;
    wait_reqs(2);
    HOLD = 1'b1;
    for (int i = 0; i < 50 && imm_cnt == b_imm; i++) tick();
    tests++; if (IMM !== 4'h5 || imm_cnt - b_imm != 1) begin fails++; $display("FAIL hold_arg: imm %h pulses %0d want 5 1", IMM, imm_cnt - b_imm); end
    repeat (5) tick();
    tests++; if (nreq - b_req != 2 || PC !== 12'h002 || MEM_REQ !== 1'b0) begin fails++; $display("FAIL hold_after: reqs %0d pc %h req %b want 2 002 0", nreq - b_req, PC, MEM_REQ); end
  endtask

  task automatic test_reset_mid();
    clear_mem(); wait_n = 0;
    mem[0] = 4'h1; mem[1] = 4'hF; mem[2] = 4'hF; mem[3] = 4'hE; mem[12'hFFE] = 4'h2;
    slow_addr = 12'hFFF; slow_en = 1'b1;
    do_reset(); snap();
    HOLD = 1'b0;
    wait_reqs(4);
    repeat (2) tick();
    tests++; if (PC !== 12'hFFF || MEM_REQ !== 1'b1 || ADDR !== 12'hFFF) begin fails++; $display("FAIL mid_wait: pc %h req %b addr %h want fff 1 fff", PC, MEM_REQ, ADDR); end
    RST = 1'b0;
    tick();
    tests++; if (MEM_REQ !== 1'b0 || PC !== 12'h000) begin fails++; $display("FAIL mid_reset: req %b pc %h want 0 000", MEM_REQ, PC); end
    HOLD = 1'b1; RST = 1'b1; slow_en = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    clear_mem(); wait_n = 0;
    mem[0] = 4'h1; mem[1] = 4'hF; mem[2] = 4'hF; mem[3] = 4'hF;
    do_reset(); snap();
    HOLD = 1'b0;
    wait_reqs(4);
    tests++; if (req_a[b_req+2] !== 12'hFFF || req_a[b_req+3] !== 12'h000) begin fails++; $display("FAIL wrap_op: %h %h want fff 000", req_a[b_req+2], req_a[b_req+3]); end
    // load-immediate at FFF: its operand comes from 000 after the wrap
    mem[12'hFFF] = 4'h2;
    do_reset(); snap();
    HOLD = 1'b0;
    wait_reqs(4);
    for (int i = 0; i < 50 && imm_cnt == b_imm; i++) tick();
    tests++; if (IMM !== 4'h1 || PC !== 12'h001 || req_a[b_req+3] !== 12'h000) begin fails++; $display("FAIL wrap_arg: imm %h pc %h arg %h want 1 001 000", IMM, PC, req_a[b_req+3]); end
    tests++; if (both_cnt != 0) begin fails++; $display("FAIL latch_imm_overlap: %0d want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_jump();
    test_ldd();
    test_priority();
    test_hold();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
